dm_l1_cache: RTL and testbench
==============================

Name: dm_l1_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 cache; the responder on the CPU memory port.
- Generates the `mem_resp` that the pipeline stall logic consumes. Instantiated twice: once as I-cache (`instr_mem_resp`) and once as D-cache (`data_mem_resp`).
- Hits respond combinationally in the request cycle. Misses stall the requester while the cache writes back the victim line and fills the new line over a 256-bit burst physical-memory port.

Parameters:
- S_INDEX, default 3: index bits; number of sets = 2**S_INDEX (default 8). Legal range 1..6.
- Line size is fixed at 32 bytes (5 offset bits). Tag width = 27 - S_INDEX.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  1  CPU read request.
- mem_write  in  1  CPU write request.
- mem_byte_enable  in  4  write byte mask.
- mem_address  in  32  CPU byte address (bits 1:0 ignored).
- mem_wdata  in  32  CPU write data.
- mem_rdata  out  32  CPU read data.
- mem_resp  out  1  request complete this cycle.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  32  line address, bits 4:0 always 0.
- pmem_wdata  out  256  writeback line.
- pmem_rdata  in  256  fill line.
- pmem_resp  in  1  physical memory transaction complete.
- hit_count  out  32  hit counter (see Optional Feature).
- miss_count  out  32  miss counter (see Optional Feature).

Behaviour:
- Address split: offset [4:0]; word select [4:2]; index [4+S_INDEX:5]; tag [31:5+S_INDEX].
- Storage is flip-flop based: per set, a valid bit, a dirty bit, a tag and a 256-bit line. Reads of storage are combinational.
- req = mem_read | mem_write. If both are high, the request is treated as a write.
- hit = req & valid[index] & (tag[index] == addr tag).
- Reset (async): state goes to IDLE and all valid/dirty bits clear.
  - All outputs are 0 during and after reset: mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata.
  - Tag and data arrays are not reset.
  - Reset asserted mid-WRITEBACK or mid-ALLOCATE drops pmem_read/pmem_write immediately; the partial transaction is abandoned.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - On hit: mem_resp=1 in the same cycle (zero-cycle hit latency).
  - Read hit: mem_rdata = line word [word select].
  - Write hit: at the clock edge, each byte with mem_byte_enable[i]=1 is merged into that word. Dirty is set only if mem_byte_enable != 0. A mask of 0 still responds.
  - On req & !hit: mem_resp=0. Go to WRITEBACK if valid & dirty, else go to ALLOCATE.
  - No req: stay in IDLE, all outputs 0.
- WRITEBACK:
  - pmem_write=1; pmem_address={stored tag, index, 5'b0}; pmem_wdata = stored line.
  - Hold these values until pmem_resp. On pmem_resp: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1; pmem_address={request tag, index, 5'b0}.
  - On pmem_resp: write pmem_rdata to the line, store the tag, valid=1, dirty=0, go to IDLE.
  - The next cycle in IDLE hits and responds. Miss latency = writeback cycles + fill cycles + 1.
- mem_resp is never asserted outside IDLE. mem_rdata is 0 whenever mem_resp=0.
- Requester protocol: address, data and mask must be held stable while req=1 and mem_resp=0.
  - Request deasserted mid-miss: the in-flight pmem transaction and the fill complete anyway, then the FSM returns to IDLE with no response.
- pmem_read and pmem_write are never both high.
- pmem_resp arriving while in IDLE is ignored.

Optional Feature:
- Macro: DM_L1_CACHE_PERF_CNT_EN.
- Defined:
  - hit_count increments on every IDLE cycle with hit=1.
  - miss_count increments on every IDLE→{WRITEBACK, ALLOCATE} transition.
  - Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
  - A retried access after a fill counts one miss and one hit.
- Not defined: hit_count and miss_count are tied to 0 and no counter flops are inferred.

Test Plan:
- Cold read at 0x0000_0040 with pmem_resp after 3 cycles and pmem_rdata word2=0xDEADBEEF, address 0x48: required sequence is pmem_read=1 with pmem_address=0x40 for 3 cycles, then IDLE, then the next cycle mem_resp=1 with mem_rdata=0xDEADBEEF; pmem_write stays 0 throughout.
- Write hit at 0x48, mask 4'b0011, wdata 0x12345678 → mem_resp=1 the same cycle. A following read of 0x48 returns 0xDEAD5678.
- Conflict read at 0x0000_0148 (same index, new tag) on the now-dirty set:
  - pmem_write=1 with pmem_address=0x40 and pmem_wdata word2=0xDEAD5678 until pmem_resp.
  - Then pmem_read=1 with pmem_address=0x140; then mem_resp=1.
- Read and write both high on a hit → treated as a write; mem_resp=1; dirty is set.
- Assert rst during ALLOCATE → pmem_read=0 immediately; a subsequent read of 0x40 misses (valid was cleared).
- With DM_L1_CACHE_PERF_CNT_EN defined: 1 cold miss then 4 hits → miss_count=1, hit_count=5. Preload hit_count to 0xFFFFFFFF, then 1 hit → hit_count=0.

Source files
------------

// File: rtl/dm_l1_cache_if.sv
// CPU-side request/response port and 256-bit line-burst physical-memory port of dm_l1_cache.
// Pure wiring, no latency of its own.
// Backpressure: the slave holds mem_resp low to stall the CPU; physical memory stalls the cache by withholding pmem_resp.
interface dm_l1_cache_if;
    // CPU memory port
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    // Physical memory port
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    // Cache side: responds to the CPU, requests from physical memory
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Environment side: CPU requester plus physical memory responder
    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dm_l1_cache.sv
// Direct-mapped write-back/write-allocate L1 cache; flop-based sets of 32-byte lines; optional counters via DM_L1_CACHE_PERF_CNT_EN.
// Latency: hits respond combinationally in the request cycle; a miss costs writeback cycles + fill cycles + 1.
// Backpressure: mem_resp stays low while a miss is serviced; each pmem request is held until pmem_resp.
module dm_l1_cache #(
    parameter int S_INDEX = 3
) (
    input  logic              clk,
    input  logic              rst,
    dm_l1_cache_if.slave      bus,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]    dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [TAG_W-1:0]   tag_d  [SETS];
    logic [255:0]       line_q [SETS];
    logic [255:0]       line_d [SETS];
    // Line address of the miss being serviced, so the fill completes even if the requester walks away
    logic [26:0]        miss_line_q, miss_line_d;

    logic               req;
    logic               hit;
    logic [S_INDEX-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         word_sel;
    logic [S_INDEX-1:0] mis_idx;
    logic [TAG_W-1:0]   mis_tag;
    logic [31:0]        cur_word;
    logic [31:0]        merged_word;

    assign req      = bus.mem_read | bus.mem_write;
    assign req_idx  = bus.mem_address[4+S_INDEX:5];
    assign req_tag  = bus.mem_address[31:5+S_INDEX];
    assign word_sel = bus.mem_address[4:2];
    assign mis_idx  = miss_line_q[S_INDEX-1:0];
    assign mis_tag  = miss_line_q[26:S_INDEX];
    assign hit      = req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign cur_word = line_q[req_idx][word_sel*32 +: 32];

    // Byte-masked merge of the CPU write data into the addressed word
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_byte_enable[b]) begin
                merged_word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
            end
        end
    end

    // Next-state, storage update and all port outputs; outputs idle at 0 unless a state drives them
    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        tag_d            = tag_q;
        line_d           = line_q;
        miss_line_d      = miss_line_q;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    bus.mem_resp = 1'b1;
                    if (bus.mem_write) begin
                        // A write wins when read and write are both requested
                        line_d[req_idx][word_sel*32 +: 32] = merged_word;
                        if (bus.mem_byte_enable != 4'b0000) begin
                            dirty_d[req_idx] = 1'b1;
                        end
                    end else begin
                        bus.mem_rdata = cur_word;
                    end
                end else if (req) begin
                    miss_line_d = bus.mem_address[31:5];
                    state_d     = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[mis_idx], mis_idx, 5'b00000};
                bus.pmem_wdata   = line_q[mis_idx];
                if (bus.pmem_resp) begin
                    dirty_d[mis_idx] = 1'b0;
                    state_d          = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {miss_line_q, 5'b00000};
                if (bus.pmem_resp) begin
                    line_d[mis_idx]  = bus.pmem_rdata;
                    tag_d[mis_idx]   = mis_tag;
                    valid_d[mis_idx] = 1'b1;
                    dirty_d[mis_idx] = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and per-set valid/dirty bits; reset invalidates every set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_line_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            miss_line_q <= miss_line_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard their contents
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

`ifdef DM_L1_CACHE_PERF_CNT_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Hits count every responding IDLE cycle; misses count each departure from IDLE
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && hit) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (state_q == IDLE && req && !hit) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    // Free-running wrapping counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_dm_l1_cache.sv
// Self-checking bench for dm_l1_cache: directed scenarios plus randomized traffic against a flat-memory reference.
// Requests are driven one at a time; a monitor checks each response's data and latency from a scoreboard queue.
// Physical memory is modelled with a programmable response latency.
module tb_dm_l1_cache;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dm_l1_cache_if bus();

    dm_l1_cache #(.S_INDEX(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int pmem_lat = 3;
    int rd_cycles = 0;
    int wr_cycles = 0;
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_word2, last_rdata;
    exp_t sb_q[$];

    // Reference: flat CPU-visible memory, physical memory, and which line each set holds
    logic [31:0]  ref_mem [int unsigned];
    logic [255:0] pm_line [int unsigned];
    bit           m_valid [8];
    bit           m_dirty [8];
    int unsigned  m_tag   [8];
    int unsigned  m_hits = 0;
    int unsigned  m_misses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] pm_get(input int unsigned la);
        logic [255:0] l;
        if (pm_line.exists(la)) return pm_line[la];
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = ((la * 8 + w) * 32'h9E3779B1) ^ 32'hA5A50F0F;
        end
        return l;
    endfunction

    function automatic logic [31:0] ref_get(input int unsigned wa);
        logic [255:0] l;
        if (ref_mem.exists(wa)) return ref_mem[wa];
        l = pm_get(wa >> 3);
        return l[(wa % 8) * 32 +: 32];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Physical memory: answers after pmem_lat request cycles; a write lands only when acknowledged
    initial begin
        int pm_cnt;
        pm_cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (!rst && (bus.pmem_read || bus.pmem_write)) begin
                if (bus.pmem_read) begin
                    rd_cycles++;
                    last_rd_addr = bus.pmem_address;
                end else begin
                    wr_cycles++;
                    last_wr_addr  = bus.pmem_address;
                    last_wr_word2 = bus.pmem_wdata[95:64];
                end
                pm_cnt++;
                if (pm_cnt >= pmem_lat) begin
                    pm_cnt = 0;
                    if (bus.pmem_write) pm_line[bus.pmem_address >> 5] = bus.pmem_wdata;
                    else bus.pmem_rdata = pm_get(bus.pmem_address >> 5);
                    bus.pmem_resp = 1'b1;
                end
            end else begin
                pm_cnt = 0;
            end
        end
    end

    // Response monitor: every mem_resp pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("pmem_rd_wr_exclusive", 32'(bus.pmem_read & bus.pmem_write), 32'd0);
            if (bus.mem_resp) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_latency", 32'(cyc - start_cyc), 32'(e.lat));
                    if (e.chk_rdata) chk("resp_rdata", bus.mem_rdata, e.rdata);
                end
            end else begin
                chk("rdata_zero_without_resp", bus.mem_rdata, 32'd0);
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [3:0] be, input logic [31:0] wd);
        int unsigned set, tagv, wa;
        bit hit, got;
        logic [31:0] nw;
        exp_t e;
        set  = (a >> 5) & 7;
        tagv = a >> 8;
        wa   = a >> 2;
        hit  = m_valid[set] && (m_tag[set] == tagv);
        if (hit) e.lat = 0;
        else if (m_valid[set] && m_dirty[set]) e.lat = 2 * pmem_lat + 1;
        else e.lat = pmem_lat + 1;
        if (!hit) begin
            m_misses++;
            m_valid[set] = 1'b1;
            m_tag[set]   = tagv;
            m_dirty[set] = 1'b0;
        end
        m_hits++;
        e.addr = a;
        e.chk_rdata = !wr;
        e.rdata = '0;
        if (wr) begin
            nw = ref_get(wa);
            for (int b = 0; b < 4; b++) if (be[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[wa] = nw;
            if (be != 4'b0000) m_dirty[set] = 1'b1;
        end else begin
            e.rdata = ref_get(wa);
        end
        rd_cycles = 0;
        wr_cycles = 0;
        @(posedge clk);
        #1;
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.mem_byte_enable = be;
        bus.mem_address = a;
        bus.mem_wdata = wd;
        start_cyc = cyc;
        sb_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                got = 1'b1;
                last_rdata = bus.mem_rdata;
            end
        end
        chk("resp_within_budget", 32'(got), 32'd1);
        if (!got) sb_q.delete();
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        logic [255:0] l;
        int r;
        rst = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_byte_enable = 4'b0000;
        bus.mem_address = '0;
        bus.mem_wdata = '0;
        l = pm_get(2);
        l[95:64] = 32'hDEADBEEF;
        pm_line[2] = l;

        // Outputs during and just after reset
        repeat (2) @(negedge clk);
        chk("rst_mem_resp", 32'(bus.mem_resp), 32'd0);
        chk("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
        chk("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
        chk("rst_pmem_address", bus.pmem_address, 32'd0);
        chk("rst_pmem_wdata_w2", bus.pmem_wdata[95:64], 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_resp", 32'(bus.mem_resp), 32'd0);
        chk("post_rst_pmem_read", 32'(bus.pmem_read), 32'd0);

        // Cold read miss with a 3-cycle fill
        pmem_lat = 3;
        do_req(32'h48, 1'b1, 1'b0, 4'h0, 32'h0);
        chk("cold_rdata", last_rdata, 32'hDEADBEEF);
        chk("cold_fill_cycles", 32'(rd_cycles), 32'd3);
        chk("cold_no_writeback", 32'(wr_cycles), 32'd0);
        chk("cold_fill_addr", last_rd_addr, 32'h40);

        // Partial write hit, then read back the merged word
        do_req(32'h48, 1'b0, 1'b1, 4'b0011, 32'h12345678);
        do_req(32'h48, 1'b1, 1'b0, 4'h0, 32'h0);
        chk("write_merge", last_rdata, 32'hDEAD5678);

        // Conflict miss on the dirty set: writeback then fill
        do_req(32'h148, 1'b1, 1'b0, 4'h0, 32'h0);
        chk("conflict_wb_cycles", 32'(wr_cycles), 32'd3);
        chk("conflict_wb_addr", last_wr_addr, 32'h40);
        chk("conflict_wb_word2", last_wr_word2, 32'hDEAD5678);
        chk("conflict_fill_addr", last_rd_addr, 32'h140);

        // Read and write together on a hit act as a write and dirty the line
        do_req(32'h14C, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D);
        do_req(32'h48, 1'b1, 1'b0, 4'h0, 32'h0);
        chk("both_high_dirty_wb", 32'(wr_cycles), 32'd3);
        chk("both_high_wb_addr", last_wr_addr, 32'h140);
        chk("refill_rdata", last_rdata, 32'hDEAD5678);

        // Reset in the middle of a fill abandons it and invalidates the cache
        pmem_lat = 10;
        @(posedge clk);
        #1;
        bus.mem_read = 1'b1;
        bus.mem_address = 32'h1040;
        repeat (3) @(negedge clk);
        chk("abort_pmem_read_active", 32'(bus.pmem_read), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_pmem_read_dropped", 32'(bus.pmem_read), 32'd0);
        chk("abort_mem_resp", 32'(bus.mem_resp), 32'd0);
        bus.mem_read = 1'b0;
        sb_q.delete();
        ref_mem.delete();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        m_hits = 0;
        m_misses = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pmem_lat = 3;
        do_req(32'h48, 1'b1, 1'b0, 4'h0, 32'h0);
        chk("after_rst_miss_fill", 32'(rd_cycles), 32'd3);
        chk("after_rst_rdata", last_rdata, 32'hDEAD5678);

        // Randomized traffic over 4 tags x 8 sets x 8 words
        for (int i = 0; i < 400; i++) begin
            pmem_lat = $urandom_range(1, 3);
            r = $urandom_range(0, 3);
            do_req({22'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 2'b00},
                   r != 2, r >= 2, 4'($urandom_range(0, 15)), $urandom);
        end

`ifdef DM_L1_CACHE_PERF_CNT_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`else
        chk("hit_count_tied", hit_count, 32'd0);
        chk("miss_count_tied", miss_count, 32'd0);
`endif
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
